// File: rtl/ram_access_arbiter.sv
// Shares the single-port 1024x32 data RAM between instruction fetch and the
// load/store unit. Grants one requester at a time, holds address/control for
// the RAM's one-cycle read latency, registers read data and returns a
// one-cycle ack to the granted requester.
module ram_access_arbiter #(
    parameter logic [2:0]  FETCH_CTRL = 3'b000,
    parameter int unsigned PRIO_MODE  = 0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_req,
    input  logic [9:0]       if_addr,
    output logic             if_ack,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [9:0]       d_addr,
    input  logic [2:0]       d_ctrl,
    input  logic [31:0]      d_wdata,
    output logic             d_ack,
    output logic [31:0]      rdata,
    output logic [9:0]       ram_addr,
    output logic [2:0]       ram_ctrl,
    output logic [31:0]      ram_din,
    output logic             ram_we,
    input  logic [31:0]      ram_dout,
    output logic             busy,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [CNT_W-1:0] data_cnt
);

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] ACCESS = 2'b01;
    localparam logic [1:0] WAIT   = 2'b10;
    localparam logic [1:0] RESP   = 2'b11;

    localparam logic GRANT_FETCH = 1'b0;
    localparam logic GRANT_DATA  = 1'b1;

    logic [1:0] state;
    logic [1:0] next_state;
    logic       last_grant;
    logic       gnt_data;
    logic       gnt_we;
    logic       any_req_c;
    logic       grant_data_c;

    // Arbitration: data wins if alone, in fixed-priority mode, or on its round-robin turn
    always_comb begin
        any_req_c    = if_req | d_req;
        grant_data_c = d_req && (!if_req || (PRIO_MODE != 0) || (last_grant == GRANT_FETCH));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; stores skip WAIT since nothing is read back
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (any_req_c) next_state = ACCESS;
            ACCESS:  next_state = gnt_we ? RESP : WAIT;
            WAIT:    next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Grant latch, RAM drive, read capture, acks and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= GRANT_DATA;
            gnt_data   <= GRANT_FETCH;
            gnt_we     <= 1'b0;
            if_ack     <= 1'b0;
            d_ack      <= 1'b0;
            rdata      <= '0;
            ram_addr   <= '0;
            ram_ctrl   <= '0;
            ram_din    <= '0;
            ram_we     <= 1'b0;
            busy       <= 1'b0;
            fetch_cnt  <= '0;
            data_cnt   <= '0;
        end else begin
            ram_we <= 1'b0;
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            busy   <= (next_state != IDLE);

            // Latch the winner once; later changes on the request inputs are ignored
            if (state == IDLE && any_req_c) begin
                last_grant <= grant_data_c;
                gnt_data   <= grant_data_c;
                if (grant_data_c) begin
                    gnt_we   <= d_we;
                    ram_addr <= d_addr;
                    ram_ctrl <= d_ctrl;
                    ram_din  <= d_wdata;
                    ram_we   <= d_we;
                end else begin
                    gnt_we   <= 1'b0;
                    ram_addr <= if_addr;
                    ram_ctrl <= FETCH_CTRL;
                end
            end

            // Store completes after its single write cycle
            if (state == ACCESS && gnt_we) begin
                d_ack <= 1'b1;
            end

            // Read data is valid at the end of WAIT; capture and ack the reader
            if (state == WAIT) begin
                rdata <= ram_dout;
                if (gnt_data) begin
                    d_ack <= 1'b1;
                end else begin
                    if_ack <= 1'b1;
                end
            end

            // Saturating completion counters
            if (state == RESP) begin
                if (gnt_data) begin
                    if (data_cnt != '1) data_cnt <= data_cnt + CNT_W'(1);
                end else begin
                    if (fetch_cnt != '1) fetch_cnt <= fetch_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter: a table of single transactions plus
// hand-written tie, fixed-priority/saturation and mid-transaction reset sequences.
module tb_ram_access_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [9:0]  if_addr;
    logic        d_req;
    logic        d_we;
    logic [9:0]  d_addr;
    logic [2:0]  d_ctrl;
    logic [31:0] d_wdata;
    logic [31:0] ram_dout;

    logic        if_ack, d_ack, ram_we, busy;
    logic [31:0] rdata, ram_din;
    logic [9:0]  ram_addr;
    logic [2:0]  ram_ctrl;
    logic [15:0] fetch_cnt, data_cnt;

    logic        if_ack2, d_ack2, ram_we2, busy2;
    logic [31:0] rdata2, ram_din2;
    logic [9:0]  ram_addr2;
    logic [2:0]  ram_ctrl2;
    logic [1:0]  fetch_cnt2, data_cnt2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ram_access_arbiter #(.FETCH_CTRL(3'b000), .PRIO_MODE(0), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_ctrl(d_ctrl),
        .d_wdata(d_wdata), .d_ack(d_ack), .rdata(rdata),
        .ram_addr(ram_addr), .ram_ctrl(ram_ctrl), .ram_din(ram_din),
        .ram_we(ram_we), .ram_dout(ram_dout), .busy(busy),
        .fetch_cnt(fetch_cnt), .data_cnt(data_cnt)
    );

    // Fixed-priority instance with narrow counters to reach saturation quickly
    ram_access_arbiter #(.FETCH_CTRL(3'b000), .PRIO_MODE(1), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack2),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_ctrl(d_ctrl),
        .d_wdata(d_wdata), .d_ack(d_ack2), .rdata(rdata2),
        .ram_addr(ram_addr2), .ram_ctrl(ram_ctrl2), .ram_din(ram_din2),
        .ram_we(ram_we2), .ram_dout(ram_dout), .busy(busy2),
        .fetch_cnt(fetch_cnt2), .data_cnt(data_cnt2)
    );

    typedef struct {
        logic        ifr;
        logic [9:0]  ia;
        logic        dr;
        logic        dwe;
        logic [9:0]  da;
        logic [2:0]  dc;
        logic [31:0] wd;
        logic [31:0] dout;
        int          e_cyc;
        logic        e_isd;
        logic [9:0]  e_addr;
        logic [2:0]  e_ctrl;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_ctrl = '0; d_wdata = '0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // One isolated transaction on dut; cycle 1 is the IDLE cycle where the request is first seen
    task automatic run_vec(input vec_t v, input int idx, inout int efc, inout int edc);
        int          ackc;
        logic        ackd;
        int          wec;
        logic        stable;
        logic [9:0]  a0;
        logic [2:0]  c0;
        logic [31:0] din0;
        string       tag;
        ackc = 0; ackd = 1'b0; wec = 0; stable = 1'b1;
        a0 = '0; c0 = '0; din0 = '0;
        tag = $sformatf("vec%0d", idx);
        if_req = v.ifr; if_addr = v.ia; d_req = v.dr; d_we = v.dwe;
        d_addr = v.da; d_ctrl = v.dc; d_wdata = v.wd; ram_dout = v.dout;
        for (int c = 2; c <= 8; c++) begin
            @(posedge clk); #1;
            if (ram_we) wec++;
            if (c == 2) begin
                a0 = ram_addr; c0 = ram_ctrl; din0 = ram_din;
            end else if (ram_addr !== a0 || ram_ctrl !== c0) begin
                stable = 1'b0;
            end
            if (if_ack && d_ack) chk({tag, " two_acks"}, 32'd1, 32'd0);
            if (if_ack || d_ack) begin
                ackc = c; ackd = d_ack;
                break;
            end
        end
        idle_inputs();
        chk({tag, " ack_cycle"}, 32'(ackc), 32'(v.e_cyc));
        chk({tag, " ack_is_data"}, 32'(ackd), 32'(v.e_isd));
        chk({tag, " ram_addr"}, 32'(a0), 32'(v.e_addr));
        chk({tag, " ram_ctrl"}, 32'(c0), 32'(v.e_ctrl));
        chk({tag, " addr_ctrl_stable"}, 32'(stable), 32'd1);
        chk({tag, " we_cycles"}, 32'(wec), (v.dr && v.dwe) ? 32'd1 : 32'd0);
        if (v.dr && v.dwe) chk({tag, " ram_din"}, din0, v.wd);
        chk({tag, " rdata"}, rdata, v.e_rdata);
        if (v.e_isd) edc++; else efc++;
        @(posedge clk); #1;
        chk({tag, " busy_after"}, 32'(busy), 32'd0);
        chk({tag, " fetch_cnt"}, 32'(fetch_cnt), 32'(efc));
        chk({tag, " data_cnt"}, 32'(data_cnt), 32'(edc));
    endtask

    initial begin
        int efc;
        int edc;
        int n1;
        int cyc1[4];
        logic kind1[4];
        int d2n;
        int i2n;
        int extra;

        rst = 1'b1;
        ram_dout = '0;
        idle_inputs();

        // Single-transaction table: fetch, store, halfword load, fetch at top address, store
        vecs[0] = '{1'b1, 10'h004, 1'b0, 1'b0, 10'h000, 3'b000, 32'h0,
                    32'hDEADBEEF, 4, 1'b0, 10'h004, 3'b000, 32'hDEADBEEF};
        vecs[1] = '{1'b0, 10'h000, 1'b1, 1'b1, 10'h010, 3'b000, 32'h12345678,
                    32'h0BADF00D, 3, 1'b1, 10'h010, 3'b000, 32'hDEADBEEF};
        vecs[2] = '{1'b0, 10'h000, 1'b1, 1'b0, 10'h003, 3'b110, 32'h0,
                    32'hCAFEF00D, 4, 1'b1, 10'h003, 3'b110, 32'hCAFEF00D};
        vecs[3] = '{1'b1, 10'h3FF, 1'b0, 1'b0, 10'h000, 3'b000, 32'h0,
                    32'h00000001, 4, 1'b0, 10'h3FF, 3'b000, 32'h00000001};
        vecs[4] = '{1'b0, 10'h000, 1'b1, 1'b1, 10'h000, 3'b101, 32'hA5A5A5A5,
                    32'hFFFFFFFF, 3, 1'b1, 10'h000, 3'b101, 32'h00000001};

        do_reset();
        chk("rst if_ack", 32'(if_ack), 32'd0);
        chk("rst d_ack", 32'(d_ack), 32'd0);
        chk("rst rdata", rdata, 32'd0);
        chk("rst ram_addr", 32'(ram_addr), 32'd0);
        chk("rst ram_ctrl", 32'(ram_ctrl), 32'd0);
        chk("rst ram_din", ram_din, 32'd0);
        chk("rst ram_we", 32'(ram_we), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst fetch_cnt", 32'(fetch_cnt), 32'd0);
        chk("rst data_cnt", 32'(data_cnt), 32'd0);

        // Both requesters held high from reset: dut alternates fetch first, dut2 always serves data
        n1 = 0; d2n = 0; i2n = 0;
        for (int i = 0; i < 4; i++) begin cyc1[i] = 0; kind1[i] = 1'b0; end
        if_req = 1'b1; if_addr = 10'h020;
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'h030; d_ctrl = 3'b000;
        ram_dout = 32'h11112222;
        for (int c = 2; c <= 16; c++) begin
            @(posedge clk); #1;
            if (if_ack && d_ack) chk("tie two_acks", 32'd1, 32'd0);
            if ((if_ack || d_ack) && n1 < 4) begin
                cyc1[n1] = c; kind1[n1] = d_ack; n1++;
            end
            if (d_ack2) d2n++;
            if (if_ack2) i2n++;
        end
        idle_inputs();
        @(posedge clk); #1;
        chk("tie ack_count", 32'(n1), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("tie ack%0d_cycle", i), 32'(cyc1[i]), 32'(4 * (i + 1)));
            chk($sformatf("tie ack%0d_is_data", i), 32'(kind1[i]), 32'(i % 2));
        end
        chk("tie rdata", rdata, 32'h11112222);
        chk("tie fetch_cnt", 32'(fetch_cnt), 32'd2);
        chk("tie data_cnt", 32'(data_cnt), 32'd2);
        chk("prio d_acks", 32'(d2n), 32'd4);
        chk("prio if_acks", 32'(i2n), 32'd0);
        chk("prio fetch_cnt", 32'(fetch_cnt2), 32'd0);
        chk("prio data_cnt_saturated", 32'(data_cnt2), 32'd3);
        chk("prio busy_after", 32'(busy2), 32'd0);

        // Table-driven single transactions from a clean reset
        do_reset();
        efc = 0; edc = 0;
        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], i, efc, edc);
        end

        // Reset asserted during WAIT of a load
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'h003; d_ctrl = 3'b110; ram_dout = 32'h55AA55AA;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        chk("rst_wait busy", 32'(busy), 32'd0);
        chk("rst_wait d_ack", 32'(d_ack), 32'd0);
        chk("rst_wait ram_we", 32'(ram_we), 32'd0);
        chk("rst_wait rdata", rdata, 32'd0);
        rst = 1'b0;
        extra = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (if_ack || d_ack || ram_we || busy) extra++;
        end
        chk("rst_wait quiet_after", 32'(extra), 32'd0);
        chk("rst_wait data_cnt", 32'(data_cnt), 32'd0);

        // Reset asserted during ACCESS of a store
        d_req = 1'b1; d_we = 1'b1; d_addr = 10'h010; d_ctrl = 3'b000; d_wdata = 32'h87654321;
        @(posedge clk); #1;
        chk("rst_access we_before", 32'(ram_we), 32'd1);
        rst = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        chk("rst_access busy", 32'(busy), 32'd0);
        chk("rst_access d_ack", 32'(d_ack), 32'd0);
        chk("rst_access ram_we", 32'(ram_we), 32'd0);
        rst = 1'b0;
        extra = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (if_ack || d_ack || ram_we || busy) extra++;
        end
        chk("rst_access quiet_after", 32'(extra), 32'd0);
        chk("rst_access data_cnt", 32'(data_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
